// File: rtl/hazard_pkg.sv
// Shared forwarding encodings and the EX operand-select priority helper
// for the hazard/scoreboard unit.
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // EX/MEM result is younger than MEM/WB, so it wins when both match.
  function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
    logic [1:0] sel;
    if (ex_hit) begin
      sel = FWD_MEM;
    end else if (mem_hit) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mc_scoreboard.sv
// Countdown scoreboard for the single in-flight multi-cycle (mult/div) op:
// tracks busy, destination register and the one-cycle writeback pulse.
module mc_scoreboard
  import hazard_pkg::*;
#(
  parameter int RA_W       = 5,
  parameter int MC_LATENCY = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            accept,
  input  logic [RA_W-1:0] dest_in,
  output logic            busy,
  output logic [RA_W-1:0] dest,
  output logic            wb
);

  localparam int CNT_W = $clog2(MC_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Writeback pulse while the counter sits on its last cycle.
  always_comb begin
    wb = 1'b0;
    if (busy && (cnt_r == CNT_ONE)) begin
      wb = 1'b1;
    end else begin
      wb = 1'b0;
    end
  end

  // Load on accept (also in the completion cycle), otherwise count down to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
      dest  <= {RA_W{1'b0}};
    end else if (accept) begin
      busy  <= 1'b1;
      cnt_r <= CNT_LOAD;
      dest  <= dest_in;
    end else if (busy) begin
      if (cnt_r == CNT_ONE) begin
        busy  <= 1'b0;
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: load-use and multi-cycle hazard stalls, branch flushes,
// registered EX forwarding selects and a saturating stall-cycle counter.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int RA_W       = 5,
  parameter int MC_LATENCY = 4,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_reg_write,
  input  logic              id_mc_issue,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [RA_W-1:0]   mem_rd,
  input  logic              mem_reg_write,
  input  logic              ex_branch_taken,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mc_busy,
  output logic              mc_wb,
  output logic [STAT_W-1:0] stall_count
);

  localparam logic [RA_W-1:0]   REG_ZERO  = {RA_W{1'b0}};
  localparam logic [STAT_W-1:0] STAT_MAX  = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_ONE  = STAT_W'(1);

  logic [RA_W-1:0] mc_dest;
  logic hz_lu, hz_raw, hz_waw, hz_str, stall, accept;
  logic ex_ok, mem_ok;

  assign ex_ok  = ex_reg_write && (ex_rd != REG_ZERO);
  assign mem_ok = mem_reg_write && (mem_rd != REG_ZERO);

  assign hz_lu  = ex_mem_read && (ex_rd != REG_ZERO) &&
                  ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
  // RAW deliberately still holds in the mc_wb cycle; the value is only readable after it.
  assign hz_raw = mc_busy && (mc_dest != REG_ZERO) &&
                  ((id_use_rs && (id_rs == mc_dest)) || (id_use_rt && (id_rt == mc_dest)));
  assign hz_waw = mc_busy && (mc_dest != REG_ZERO) &&
                  (id_reg_write || id_mc_issue) && (id_rd == mc_dest);
  assign hz_str = id_mc_issue && mc_busy && !mc_wb;
  assign stall  = !ex_branch_taken && (hz_lu || hz_raw || hz_waw || hz_str);
  assign accept = id_mc_issue && !stall && !ex_branch_taken;

  mc_scoreboard #(
    .RA_W       (RA_W),
    .MC_LATENCY (MC_LATENCY)
  ) u_mc_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .accept  (accept),
    .dest_in (id_rd),
    .busy    (mc_busy),
    .dest    (mc_dest),
    .wb      (mc_wb)
  );

  // Pipeline control: a taken branch squashes and overrides any stall.
  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end else begin
      idex_flush = 1'b0;
    end
  end

  // Forwarding selects for the instruction entering EX; a bubble forwards nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_a <= FWD_REG;
      fwd_b <= FWD_REG;
    end else if (idex_flush) begin
      fwd_a <= FWD_REG;
      fwd_b <= FWD_REG;
    end else begin
      fwd_a <= fwd_pick(ex_ok && (ex_rd == id_rs), mem_ok && (mem_rd == id_rs));
      fwd_b <= fwd_pick(ex_ok && (ex_rd == id_rt), mem_ok && (mem_rd == id_rt));
    end
  end

  // Saturating stall-cycle statistic.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= {STAT_W{1'b0}};
    end else if (stall && (stall_count != STAT_MAX)) begin
      stall_count <= stall_count + STAT_ONE;
    end else begin
      stall_count <= stall_count;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with hand-computed expectations
// (STAT_W reduced to 4 so counter saturation is reachable).
module tb_hazard_scoreboard_unit;

  localparam int RA_W = 5;
  localparam int STAT_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic [RA_W-1:0] id_rs, id_rt, id_rd, ex_rd, mem_rd;
  logic id_use_rs, id_use_rt, id_reg_write, id_mc_issue;
  logic ex_reg_write, ex_mem_read, mem_reg_write, ex_branch_taken;
  logic pc_stall, ifid_stall, ifid_flush, idex_flush, mc_busy, mc_wb;
  logic [1:0] fwd_a, fwd_b;
  logic [STAT_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.RA_W(RA_W), .MC_LATENCY(4), .STAT_W(STAT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mc_issue(id_mc_issue),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .ex_branch_taken(ex_branch_taken),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .mc_busy(mc_busy),
    .mc_wb(mc_wb), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_reg_write = 1'b0; id_mc_issue = 1'b0;
    ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = 5'd0; mem_reg_write = 1'b0; ex_branch_taken = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_pc_stall", pc_stall, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_mc_busy", mc_busy, 0);
    chk("rst_count", stall_count, 0);

    // 1: load-use on rs=8, one stall then MEM/WB forward
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd8;
    id_rs = 5'd8; id_use_rs = 1'b1; id_rd = 5'd9; id_reg_write = 1'b1;
    #1;
    chk("lu_pc_stall", pc_stall, 1);
    chk("lu_ifid_stall", ifid_stall, 1);
    chk("lu_idex_flush", idex_flush, 1);
    chk("lu_ifid_flush", ifid_flush, 0);
    tick();
    chk("lu_bubble_fwd_a", fwd_a, 0);
    chk("lu_count", stall_count, 1);
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
    mem_rd = 5'd8; mem_reg_write = 1'b1;
    #1;
    chk("lu_released", pc_stall, 0);
    tick();
    chk("lu_fwd_a", fwd_a, 1);
    chk("lu_fwd_b", fwd_b, 0);

    // 2: forwarding priority and register 0
    idle();
    ex_rd = 5'd3; ex_reg_write = 1'b1; mem_rd = 5'd3; mem_reg_write = 1'b1;
    id_rt = 5'd3; id_use_rt = 1'b1;
    tick();
    chk("fwd_b_ex", fwd_b, 2);
    ex_reg_write = 1'b0;
    tick();
    chk("fwd_b_mem", fwd_b, 1);
    id_rt = 5'd0;
    tick();
    chk("fwd_b_reg", fwd_b, 0);
    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    #1;
    chk("r0_no_lu", pc_stall, 0);

    // 3: mult to r5, dependent read stalls through the mc_wb cycle
    idle();
    id_mc_issue = 1'b1; id_rd = 5'd5;
    #1;
    chk("mc_issue_nostall", pc_stall, 0);
    tick();
    chk("mc_busy_set", mc_busy, 1);
    idle();
    id_rs = 5'd5; id_use_rs = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("raw_stall", pc_stall, 1);
      chk("raw_mc_wb", mc_wb, (i == 4) ? 1 : 0);
      tick();
    end
    #1;
    chk("raw_done", pc_stall, 0);
    chk("raw_busy_clear", mc_busy, 0);
    chk("raw_count", stall_count, 5);

    // 4: structural hazard, second issue accepted in the completion cycle
    idle();
    id_mc_issue = 1'b1; id_rd = 5'd5;
    tick();
    idle();
    tick();
    id_mc_issue = 1'b1; id_rd = 5'd6;
    #1;
    chk("str_stall_c2", pc_stall, 1);
    tick();
    chk("str_stall_c3", pc_stall, 1);
    tick();
    chk("str_wb_c4", mc_wb, 1);
    chk("str_accept_c4", pc_stall, 0);
    tick();
    idle();
    #1;
    chk("str_busy_c5", mc_busy, 1);
    chk("str_nowb_c5", mc_wb, 0);
    tick(); tick();
    chk("str_nowb_c7", mc_wb, 0);
    tick();
    chk("str_wb_c8", mc_wb, 1);
    tick();
    chk("str_idle_c9", mc_busy, 0);
    chk("str_count", stall_count, 7);

    // 5: taken branch overrides load-use
    idle();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd8;
    id_rs = 5'd8; id_use_rs = 1'b1; ex_branch_taken = 1'b1;
    #1;
    chk("br_ifid_flush", ifid_flush, 1);
    chk("br_idex_flush", idex_flush, 1);
    chk("br_pc_stall", pc_stall, 0);
    chk("br_ifid_stall", ifid_stall, 0);
    tick();
    chk("br_count", stall_count, 7);
    chk("br_fwd_a", fwd_a, 0);

    // 6: reset abandons an in-flight op (WAW seen just before)
    idle();
    id_mc_issue = 1'b1; id_rd = 5'd7;
    tick();
    idle();
    ex_rd = 5'd3; ex_reg_write = 1'b1; id_rt = 5'd3;
    tick();
    chk("pre_rst_fwd_b", fwd_b, 2);
    id_reg_write = 1'b1; id_rd = 5'd7;
    #1;
    chk("waw_stall", pc_stall, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    id_rs = 5'd7; id_use_rs = 1'b1;
    #1;
    chk("rst_abandon_busy", mc_busy, 0);
    chk("rst_abandon_fwd_b", fwd_b, 0);
    chk("rst_abandon_count", stall_count, 0);
    for (int i = 0; i < 5; i++) begin
      chk("rst_no_stall", pc_stall, 0);
      chk("rst_no_wb", mc_wb, 0);
      tick();
    end

    // 7: stall counter saturates at 15
    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd4; id_rt = 5'd4; id_use_rt = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_count_14", stall_count, 14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_count_15", stall_count, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
